ram_sp_arbiter: RTL and testbench
=================================

Name: ram_sp_arbiter

Overview:
Two-requester arbiter and sequencer for an internal 64x8 single-port RAM with a registered read address. Requesters A and B issue single-cycle read or write accesses. The block grants one requester per cycle using round-robin priority, with optional bounded lock ownership for bursts. It returns read data one cycle after an accepted read, tagged with a per-requester valid. It sits between two client engines and the shared buffer memory.

Parameters:
DATA_W, 8, RAM word width
ADDR_W, 6, RAM address width (depth = 2**ADDR_W = 64)
MAX_LOCK, 8, max consecutive granted cycles a locked owner keeps the RAM while the other side is requesting (range 2..255)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req_a  input  1  A requests an access this cycle
we_a  input  1  A access is a write (1) or read (0)
lock_a  input  1  A requests to keep ownership after this access
addr_a  input  ADDR_W  A address
wdata_a  input  DATA_W  A write data
gnt_a  output  1  A access accepted at this clock edge (combinational)
rvalid_a  output  1  rdata_a valid (cycle after accepted A read)
rdata_a  output  DATA_W  A read data, 0 when rvalid_a=0
req_b, we_b, lock_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as A, for requester B

Behaviour:
- Reset (async, rst=1): state=IDLE; last_gnt=B, so A wins the first tie; lock_cnt=0; rvalid_a/b=0; gnt_a/b forced 0; rdata_a/b=0; read address register=0. RAM contents are not reset.
- Access accepted at edge when req_x & gnt_x. At most one of gnt_a/gnt_b is high in any cycle. gnt_x is never high without req_x.
- Write accept: ram[addr_x] <= wdata_x at that edge.
- Read accept: addr_x is registered at the edge. Next cycle rvalid_x=1 and rdata_x=ram[raddr_q]. Latency 1.
- A read accepted the cycle after a write to the same address returns the new data.
- rvalid is 1 cycle per accepted read. Back-to-back reads give continuous rvalid.
- States:
  - IDLE: round-robin. If only one side requests, it is granted. If both request, grant the side != last_gnt. If the granted access has lock_x=1, go to OWN_x with lock_cnt=1.
  - OWN_A / OWN_B: owner has priority while req_owner=1.
  - Each cycle in OWN_x with both requests, the owner is granted and lock_cnt increments.
  - lock_cnt resets to 0 whenever the other side is not requesting.
  - Leave to IDLE when the owner is granted with lock=0, or when req_owner=0 (the other side may then be granted in that same cycle).
  - If lock_cnt reaches MAX_LOCK while the other side requests, next cycle goes to IDLE with last_gnt=owner, so the other side wins.
- last_gnt updates on every accepted access.
- rst mid-operation: a pending rvalid is dropped and ownership is cleared. Writes at or after the reset edge do not occur.

Optional Feature:
RAM_ARB_CONFLICT_CNT_EN
- Defined: adds output conflict_cnt [7:0]. Counts cycles with req_a & req_b. Saturates at 255, reset to 0.
- Undefined: the port and counter are absent. Arbitration is unchanged.

Test Plan:
1. After reset, A writes 0x5A to addr 3 (gnt_a=1), then A reads addr 3 -> next cycle rvalid_a=1, rdata_a=0x5A, rvalid_b=0.
2. A and B request simultaneously for 4 cycles, no lock -> grants A,B,A,B. Conflict_cnt=4 if enabled.
3. Write 0x11 to addr 10 in cycle n, read addr 10 in cycle n+1 -> rdata=0x11 in cycle n+2, not the stale value.
4. B holds req_b=lock_b=1 reading addrs 0..15 while A requests continuously, MAX_LOCK=8 -> B gets 8 consecutive grants, then A is granted, and rvalid_b tracks each B read.
5. Accepted A read, rst pulsed before the next edge -> rvalid_a stays 0, both grants 0 during reset, and A wins the first tie after release.
6. Only B requests with we_b=1 and addr 63 (wrap boundary) -> gnt_b=1 every cycle, gnt_a=0, then ram[63] reads back the correct value.

Source files
------------

// File: rtl/ram_sp_arbiter_if.sv
// Bus bundle between the two client engines and ram_sp_arbiter.
// Clients drive the master side. The arbiter implements the slave side.
interface ram_sp_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              req_a;
  logic              we_a;
  logic              lock_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              gnt_a;
  logic              rvalid_a;
  logic [DATA_W-1:0] rdata_a;

  logic              req_b;
  logic              we_b;
  logic              lock_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              gnt_b;
  logic              rvalid_b;
  logic [DATA_W-1:0] rdata_b;

  modport master (
    output req_a, we_a, lock_a, addr_a, wdata_a,
    output req_b, we_b, lock_b, addr_b, wdata_b,
    input  gnt_a, rvalid_a, rdata_a,
    input  gnt_b, rvalid_b, rdata_b
  );

  modport slave (
    input  req_a, we_a, lock_a, addr_a, wdata_a,
    input  req_b, we_b, lock_b, addr_b, wdata_b,
    output gnt_a, rvalid_a, rdata_a,
    output gnt_b, rvalid_b, rdata_b
  );
endinterface

// File: rtl/ram_sp_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// The RAM has a registered read address. A granted access can be extended
// into bounded lock ownership. Read data arrives one cycle after the grant.
// Optional build macro RAM_ARB_CONFLICT_CNT_EN adds the conflict_cnt output.
// conflict_cnt is a saturating count of cycles in which both sides requested.
module ram_sp_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int MAX_LOCK = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef RAM_ARB_CONFLICT_CNT_EN
  output logic [7:0] conflict_cnt,
`endif
  ram_sp_arbiter_if.slave bus
);

  localparam int         DEPTH      = 1 << ADDR_W;
  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);
  localparam logic       LG_A       = 1'b0;
  localparam logic       LG_B       = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [7:0]        lock_cnt_r;
  logic [7:0]        lock_cnt_nxt_s;
  logic [7:0]        lock_cnt_inc_s;
  logic              last_gnt_r;
  logic              gnt_a_s;
  logic              gnt_b_s;
  logic              wr_en_s;
  logic              rd_en_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic [DATA_W-1:0] acc_wdata_s;
  logic [ADDR_W-1:0] raddr_r;
  logic              rvalid_a_r;
  logic              rvalid_b_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  assign lock_cnt_inc_s = lock_cnt_r + 8'd1;

  // Grant selection and ownership next-state. The grants are combinational and are held low during reset.
  always_comb begin
    state_nxt_s    = state_r;
    lock_cnt_nxt_s = lock_cnt_r;
    gnt_a_s        = 1'b0;
    gnt_b_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_a && (!bus.req_b || (last_gnt_r == LG_B))) begin
          gnt_a_s = 1'b1;
        end else if (bus.req_b) begin
          gnt_b_s = 1'b1;
        end else begin
          gnt_a_s = 1'b0;
          gnt_b_s = 1'b0;
        end
        if (gnt_a_s && bus.lock_a) begin
          state_nxt_s    = ST_OWN_A;
          lock_cnt_nxt_s = bus.req_b ? 8'd1 : 8'd0;
        end else if (gnt_b_s && bus.lock_b) begin
          state_nxt_s    = ST_OWN_B;
          lock_cnt_nxt_s = bus.req_a ? 8'd1 : 8'd0;
        end else begin
          state_nxt_s    = ST_IDLE;
          lock_cnt_nxt_s = 8'd0;
        end
      end
      ST_OWN_A: begin
        if (bus.req_a) begin
          gnt_a_s = 1'b1;
          if (!bus.lock_a) begin
            state_nxt_s    = ST_IDLE;
            lock_cnt_nxt_s = 8'd0;
          end else if (!bus.req_b) begin
            state_nxt_s    = ST_OWN_A;
            lock_cnt_nxt_s = 8'd0;
          end else if (lock_cnt_inc_s >= MAX_LOCK_C) begin
            // Lock budget spent: B wins next because last_gnt becomes A.
            state_nxt_s    = ST_IDLE;
            lock_cnt_nxt_s = 8'd0;
          end else begin
            state_nxt_s    = ST_OWN_A;
            lock_cnt_nxt_s = lock_cnt_inc_s;
          end
        end else begin
          gnt_b_s        = bus.req_b;
          state_nxt_s    = ST_IDLE;
          lock_cnt_nxt_s = 8'd0;
        end
      end
      ST_OWN_B: begin
        if (bus.req_b) begin
          gnt_b_s = 1'b1;
          if (!bus.lock_b) begin
            state_nxt_s    = ST_IDLE;
            lock_cnt_nxt_s = 8'd0;
          end else if (!bus.req_a) begin
            state_nxt_s    = ST_OWN_B;
            lock_cnt_nxt_s = 8'd0;
          end else if (lock_cnt_inc_s >= MAX_LOCK_C) begin
            state_nxt_s    = ST_IDLE;
            lock_cnt_nxt_s = 8'd0;
          end else begin
            state_nxt_s    = ST_OWN_B;
            lock_cnt_nxt_s = lock_cnt_inc_s;
          end
        end else begin
          gnt_a_s        = bus.req_a;
          state_nxt_s    = ST_IDLE;
          lock_cnt_nxt_s = 8'd0;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        lock_cnt_nxt_s = 8'd0;
      end
    endcase
    if (rst) begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
    end else begin
      gnt_a_s = gnt_a_s;
      gnt_b_s = gnt_b_s;
    end
  end

  assign bus.gnt_a   = gnt_a_s;
  assign bus.gnt_b   = gnt_b_s;
  assign acc_addr_s  = gnt_b_s ? bus.addr_b  : bus.addr_a;
  assign acc_wdata_s = gnt_b_s ? bus.wdata_b : bus.wdata_a;
  assign wr_en_s     = (gnt_a_s && bus.we_a) || (gnt_b_s && bus.we_b);
  assign rd_en_s     = (gnt_a_s && !bus.we_a) || (gnt_b_s && !bus.we_b);

  // Arbiter state, lock counter and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      lock_cnt_r <= 8'd0;
      last_gnt_r <= LG_B;
    end else begin
      state_r    <= state_nxt_s;
      lock_cnt_r <= lock_cnt_nxt_s;
      if (gnt_a_s) begin
        last_gnt_r <= LG_A;
      end else if (gnt_b_s) begin
        last_gnt_r <= LG_B;
      end
    end
  end

  // Read address register and the per-requester read-valid flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr_r    <= {ADDR_W{1'b0}};
      rvalid_a_r <= 1'b0;
      rvalid_b_r <= 1'b0;
    end else begin
      rvalid_a_r <= gnt_a_s && !bus.we_a;
      rvalid_b_r <= gnt_b_s && !bus.we_b;
      if (rd_en_s) begin
        raddr_r <= acc_addr_s;
      end
    end
  end

  // RAM write port. The contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[acc_addr_s] <= acc_wdata_s;
    end
  end

  assign bus.rvalid_a = rvalid_a_r;
  assign bus.rvalid_b = rvalid_b_r;
  assign bus.rdata_a  = rvalid_a_r ? mem_r[raddr_r] : {DATA_W{1'b0}};
  assign bus.rdata_b  = rvalid_b_r ? mem_r[raddr_r] : {DATA_W{1'b0}};

`ifdef RAM_ARB_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt_r;

  // Saturating count of cycles where both requesters competed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_r <= 8'd0;
    end else if (bus.req_a && bus.req_b && (conflict_cnt_r != 8'd255)) begin
      conflict_cnt_r <= conflict_cnt_r + 8'd1;
    end
  end

  assign conflict_cnt = conflict_cnt_r;
`endif

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Directed self-checking bench for ram_sp_arbiter (DATA_W=8, ADDR_W=6, MAX_LOCK=8).
module tb_ram_sp_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

`ifdef RAM_ARB_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;
`endif

  ram_sp_arbiter_if #(.DATA_W(8), .ADDR_W(6)) bus ();

  ram_sp_arbiter #(.DATA_W(8), .ADDR_W(6), .MAX_LOCK(8)) dut (
    .clk(clk),
    .rst(rst),
`ifdef RAM_ARB_CONFLICT_CNT_EN
    .conflict_cnt(conflict_cnt),
`endif
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.lock_a = 1'b0; bus.addr_a = 6'd0; bus.wdata_a = 8'd0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.lock_b = 1'b0; bus.addr_b = 6'd0; bus.wdata_b = 8'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    bus.req_a = 1'b1; bus.req_b = 1'b1; bus.we_a = 1'b1;
    @(negedge clk);
    checks++; if (bus.gnt_a !== 1'b0) begin failures++; $display("FAIL reset_gnt_a got=%b exp=0", bus.gnt_a); end
    checks++; if (bus.gnt_b !== 1'b0) begin failures++; $display("FAIL reset_gnt_b got=%b exp=0", bus.gnt_b); end
    checks++; if (bus.rvalid_a !== 1'b0) begin failures++; $display("FAIL reset_rvalid_a got=%b exp=0", bus.rvalid_a); end
    checks++; if (bus.rvalid_b !== 1'b0) begin failures++; $display("FAIL reset_rvalid_b got=%b exp=0", bus.rvalid_b); end
    checks++; if (bus.rdata_a !== 8'h00) begin failures++; $display("FAIL reset_rdata_a got=%h exp=00", bus.rdata_a); end
`ifdef RAM_ARB_CONFLICT_CNT_EN
    checks++; if (conflict_cnt !== 8'd0) begin failures++; $display("FAIL reset_conflict got=%0d exp=0", conflict_cnt); end
`endif
    set_idle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_write_read();
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 6'd3; bus.wdata_a = 8'h5A;
    @(negedge clk);
    checks++; if (bus.gnt_a !== 1'b1) begin failures++; $display("FAIL wr_gnt_a got=%b exp=1", bus.gnt_a); end
    checks++; if (bus.gnt_b !== 1'b0) begin failures++; $display("FAIL wr_gnt_b got=%b exp=0", bus.gnt_b); end
    next_cycle();
    bus.we_a = 1'b0;
    @(negedge clk);
    checks++; if (bus.gnt_a !== 1'b1) begin failures++; $display("FAIL rd_gnt_a got=%b exp=1", bus.gnt_a); end
    next_cycle();
    set_idle();
    checks++; if (bus.rvalid_a !== 1'b1) begin failures++; $display("FAIL rd_rvalid_a got=%b exp=1", bus.rvalid_a); end
    checks++; if (bus.rdata_a !== 8'h5A) begin failures++; $display("FAIL rd_rdata_a got=%h exp=5a", bus.rdata_a); end
    checks++; if (bus.rvalid_b !== 1'b0) begin failures++; $display("FAIL rd_rvalid_b got=%b exp=0", bus.rvalid_b); end
    next_cycle();
    checks++; if (bus.rvalid_a !== 1'b0) begin failures++; $display("FAIL rd_rvalid_drop got=%b exp=0", bus.rvalid_a); end
    checks++; if (bus.rdata_a !== 8'h00) begin failures++; $display("FAIL rd_rdata_zero got=%h exp=00", bus.rdata_a); end
  endtask

  task automatic test_round_robin();
    logic exp_a;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    bus.req_a = 1'b1; bus.addr_a = 6'd3;
    bus.req_b = 1'b1; bus.addr_b = 6'd3;
    for (int i = 0; i < 4; i++) begin
      exp_a = ((i % 2) == 0);
      @(negedge clk);
      checks++; if (bus.gnt_a !== exp_a) begin failures++; $display("FAIL rr_gnt_a[%0d] got=%b exp=%b", i, bus.gnt_a, exp_a); end
      checks++; if (bus.gnt_b !== !exp_a) begin failures++; $display("FAIL rr_gnt_b[%0d] got=%b exp=%b", i, bus.gnt_b, !exp_a); end
      next_cycle();
      checks++; if (bus.rvalid_a !== exp_a) begin failures++; $display("FAIL rr_rvalid_a[%0d] got=%b exp=%b", i, bus.rvalid_a, exp_a); end
      checks++; if (bus.rvalid_b !== !exp_a) begin failures++; $display("FAIL rr_rvalid_b[%0d] got=%b exp=%b", i, bus.rvalid_b, !exp_a); end
      checks++; if ((bus.rdata_a | bus.rdata_b) !== 8'h5A) begin failures++; $display("FAIL rr_rdata[%0d] got=%h exp=5a", i, bus.rdata_a | bus.rdata_b); end
    end
    set_idle();
`ifdef RAM_ARB_CONFLICT_CNT_EN
    checks++; if (conflict_cnt !== 8'd4) begin failures++; $display("FAIL rr_conflict got=%0d exp=4", conflict_cnt); end
`endif
  endtask

  task automatic test_raw();
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 6'd10; bus.wdata_a = 8'h22;
    next_cycle();
    bus.wdata_a = 8'h11;
    next_cycle();
    bus.we_a = 1'b0;
    @(negedge clk);
    checks++; if (bus.gnt_a !== 1'b1) begin failures++; $display("FAIL raw_gnt_a got=%b exp=1", bus.gnt_a); end
    next_cycle();
    set_idle();
    checks++; if (bus.rvalid_a !== 1'b1) begin failures++; $display("FAIL raw_rvalid got=%b exp=1", bus.rvalid_a); end
    checks++; if (bus.rdata_a !== 8'h11) begin failures++; $display("FAIL raw_rdata got=%h exp=11", bus.rdata_a); end
  endtask

  task automatic test_lock();
    logic [7:0] val;
    logic [5:0] b_idx;
    logic       exp_b;
    int         b_count;
    for (int i = 0; i < 16; i++) begin
      val = 8'hA0 + 8'(i);
      bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 6'(i); bus.wdata_a = val;
      next_cycle();
    end
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.lock_a = 1'b0; bus.addr_a = 6'd3;
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.lock_b = 1'b1;
    b_idx = 6'd0;
    b_count = 0;
    for (int c = 0; c < 17; c++) begin
      bus.addr_b = b_idx;
      exp_b = (c != 8);
      @(negedge clk);
      checks++; if (bus.gnt_b !== exp_b) begin failures++; $display("FAIL lock_gnt_b[%0d] got=%b exp=%b", c, bus.gnt_b, exp_b); end
      checks++; if (bus.gnt_a !== !exp_b) begin failures++; $display("FAIL lock_gnt_a[%0d] got=%b exp=%b", c, bus.gnt_a, !exp_b); end
      next_cycle();
      checks++; if (bus.rvalid_b !== exp_b) begin failures++; $display("FAIL lock_rvalid_b[%0d] got=%b exp=%b", c, bus.rvalid_b, exp_b); end
      if (exp_b) begin
        val = 8'hA0 + {2'b00, b_idx};
        checks++; if (bus.rdata_b !== val) begin failures++; $display("FAIL lock_rdata_b[%0d] got=%h exp=%h", c, bus.rdata_b, val); end
        b_idx = b_idx + 6'd1;
        b_count++;
      end else begin
        checks++; if (bus.rvalid_a !== 1'b1) begin failures++; $display("FAIL lock_rvalid_a got=%b exp=1", bus.rvalid_a); end
        checks++; if (bus.rdata_a !== 8'hA3) begin failures++; $display("FAIL lock_rdata_a got=%h exp=a3", bus.rdata_a); end
      end
    end
    set_idle();
    checks++; if (b_count !== 16) begin failures++; $display("FAIL lock_b_count got=%0d exp=16", b_count); end
  endtask

  task automatic test_reset_mid();
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 6'd20; bus.wdata_a = 8'h33;
    next_cycle();
    bus.we_a = 1'b0; bus.addr_a = 6'd3;
    @(negedge clk);
    checks++; if (bus.gnt_a !== 1'b1) begin failures++; $display("FAIL rm_gnt_a got=%b exp=1", bus.gnt_a); end
    next_cycle();
    checks++; if (bus.rvalid_a !== 1'b1) begin failures++; $display("FAIL rm_rvalid_pre got=%b exp=1", bus.rvalid_a); end
    rst = 1'b1;
    #1;
    checks++; if (bus.rvalid_a !== 1'b0) begin failures++; $display("FAIL rm_rvalid_drop got=%b exp=0", bus.rvalid_a); end
    checks++; if (bus.rdata_a !== 8'h00) begin failures++; $display("FAIL rm_rdata_zero got=%h exp=00", bus.rdata_a); end
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 6'd20; bus.wdata_a = 8'hFF;
    bus.req_b = 1'b1;
    @(negedge clk);
    checks++; if (bus.gnt_a !== 1'b0) begin failures++; $display("FAIL rm_gnt_a_rst got=%b exp=0", bus.gnt_a); end
    checks++; if (bus.gnt_b !== 1'b0) begin failures++; $display("FAIL rm_gnt_b_rst got=%b exp=0", bus.gnt_b); end
    next_cycle();
    checks++; if (bus.rvalid_a !== 1'b0) begin failures++; $display("FAIL rm_rvalid_rst got=%b exp=0", bus.rvalid_a); end
    @(negedge clk);
    rst = 1'b0;
    bus.we_a = 1'b0; bus.addr_a = 6'd20;
    bus.we_b = 1'b0; bus.addr_b = 6'd3;
    #1;
    checks++; if (bus.gnt_a !== 1'b1) begin failures++; $display("FAIL rm_tie_gnt_a got=%b exp=1", bus.gnt_a); end
    checks++; if (bus.gnt_b !== 1'b0) begin failures++; $display("FAIL rm_tie_gnt_b got=%b exp=0", bus.gnt_b); end
    next_cycle();
    set_idle();
    checks++; if (bus.rvalid_a !== 1'b1) begin failures++; $display("FAIL rm_rvalid_after got=%b exp=1", bus.rvalid_a); end
    checks++; if (bus.rdata_a !== 8'h33) begin failures++; $display("FAIL rm_no_write_in_rst got=%h exp=33", bus.rdata_a); end
    checks++; if (bus.rvalid_b !== 1'b0) begin failures++; $display("FAIL rm_rvalid_b got=%b exp=0", bus.rvalid_b); end
  endtask

  task automatic test_wrap();
    logic [7:0] val;
    for (int i = 0; i < 3; i++) begin
      val = 8'hC1 + 8'(i);
      bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 6'd63; bus.wdata_b = val;
      @(negedge clk);
      checks++; if (bus.gnt_b !== 1'b1) begin failures++; $display("FAIL wrap_gnt_b[%0d] got=%b exp=1", i, bus.gnt_b); end
      checks++; if (bus.gnt_a !== 1'b0) begin failures++; $display("FAIL wrap_gnt_a[%0d] got=%b exp=0", i, bus.gnt_a); end
      next_cycle();
    end
    bus.we_b = 1'b0;
    @(negedge clk);
    checks++; if (bus.gnt_b !== 1'b1) begin failures++; $display("FAIL wrap_rd_gnt_b got=%b exp=1", bus.gnt_b); end
    next_cycle();
    set_idle();
    checks++; if (bus.rvalid_b !== 1'b1) begin failures++; $display("FAIL wrap_rvalid_b got=%b exp=1", bus.rvalid_b); end
    checks++; if (bus.rdata_b !== 8'hC3) begin failures++; $display("FAIL wrap_rdata_b got=%h exp=c3", bus.rdata_b); end
    checks++; if (bus.rvalid_a !== 1'b0) begin failures++; $display("FAIL wrap_rvalid_a got=%b exp=0", bus.rvalid_a); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    set_idle();
    test_reset();
    test_write_read();
    test_round_robin();
    test_raw();
    test_lock();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
